// File: rtl/jkdrv_pkg.sv
// Shared definitions for the JK excitation driver: FSM states, default
// geometry and the inverse-JK excitation function.
package jkdrv_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } drv_state_e;

    // Maps a (current Q, wanted Q) pair back to the {J,K} that produces it.
    // The free input of each pair is resolved to dc_mode.
    function automatic logic [1:0] jk_excite(input logic q,
                                             input logic q_next,
                                             input logic dc_mode);
        logic [1:0] jk;
        case ({q, q_next})
            2'b00:   jk = {1'b0, dc_mode};
            2'b01:   jk = {1'b1, dc_mode};
            2'b10:   jk = {dc_mode, 1'b1};
            2'b11:   jk = {dc_mode, 1'b0};
            default: jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jkdrv_fifo.sv
// Synchronous 1-bit FIFO holding requested target bits. The ready flag is
// registered and held low in reset, so it doubles as the upstream ready.
module jkdrv_fifo
    import jkdrv_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic empty,
    output logic last,
    output logic ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic             ready_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: a push needs a slot as of the previous edge, a pop needs data.
    always_comb begin
        push_ok_s    = push & ready_r;
        pop_ok_s     = pop & (count_r != CNT_ZERO);
        count_next_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers (natural wrap modulo DEPTH) and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            ready_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != CNT_FULL);
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == CNT_ZERO);
    assign last  = (count_r == CNT_ONE);
    assign ready = ready_r;

endmodule

// File: rtl/jk_excitation_driver.sv
// Inverse JK flop sequencer: buffers requested Q bits and turns each one into
// a registered J/K excitation, tracking the expected Q in q_model.
// Optional checker (q_obs vs delayed q_model, err pulse, saturating err_cnt)
// is built only when JKDRV_CHECK_EN is defined.
module jk_excitation_driver
    import jkdrv_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    input  logic             dc_mode,
    output logic             j,
    output logic             k,
    output logic             drv_valid,
    output logic             q_model,
    input  logic             q_obs,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    drv_state_e state_r;
    logic       j_r;
    logic       k_r;
    logic       drv_valid_r;
    logic       q_model_r;

    logic       fifo_dout_s;
    logic       fifo_empty_s;
    logic       fifo_last_s;
    logic       fifo_ready_s;
    logic       push_s;
    logic       pop_s;
    logic [1:0] jk_next_s;

    jkdrv_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .din   (tgt_bit),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .empty (fifo_empty_s),
        .last  (fifo_last_s),
        .ready (fifo_ready_s)
    );

    // Handshake and pop decision; excitation is derived from the modelled Q.
    always_comb begin
        push_s = tgt_valid & fifo_ready_s;
        if ((state_r == RUN) && !fifo_empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        jk_next_s = jk_excite(q_model_r, fifo_dout_s, dc_mode);
    end

    // FSM with registered excitation outputs; q_model follows each popped bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            j_r         <= 1'b0;
            k_r         <= 1'b0;
            drv_valid_r <= 1'b0;
            q_model_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s || push_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (fifo_empty_s || (fifo_last_s && !push_s)) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: state_r <= IDLE;
            endcase

            if (pop_s) begin
                j_r         <= jk_next_s[1];
                k_r         <= jk_next_s[0];
                drv_valid_r <= 1'b1;
                q_model_r   <= fifo_dout_s;
            end else begin
                j_r         <= 1'b0;
                k_r         <= 1'b0;
                drv_valid_r <= 1'b0;
            end
        end
    end

    assign tgt_ready = fifo_ready_s;
    assign j         = j_r;
    assign k         = k_r;
    assign drv_valid = drv_valid_r;
    assign q_model   = q_model_r;

`ifdef JKDRV_CHECK_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             chk_v_r;
    logic             chk_q_r;
    logic             err_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic             mismatch_s;

    // A delayed expectation is compared only if it came from a real excitation.
    always_comb begin
        if (chk_v_r) begin
            mismatch_s = (q_obs != chk_q_r);
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Align q_model with the flop's capture edge, then compare and count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_v_r   <= 1'b0;
            chk_q_r   <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= {CNT_W{1'b0}};
        end else begin
            chk_v_r <= drv_valid_r;
            chk_q_r <= q_model_r;
            err_r   <= mismatch_s;
            if (mismatch_s && (err_cnt_r != CNT_MAX)) begin
                err_cnt_r <= err_cnt_r + CNT_ONE;
            end
        end
    end

    assign err     = err_r;
    assign err_cnt = err_cnt_r;
`else
    logic unused_q_obs_s;

    assign unused_q_obs_s = q_obs;
    assign err            = 1'b0;
    assign err_cnt        = {CNT_W{1'b0}};
`endif

endmodule
